// File: rtl/vga_frame_mapper.sv
// Maps VGA raster positions onto a camera framebuffer window with integer zoom.
// Pipeline: stage 1 window/scale math, stage 2 address, RD_LAT-cycle memory
// read, then a registered pixel mux. One position accepted per clock.
module vga_frame_mapper #(
  parameter int CAM_SCREEN_X = 160,
  parameter int CAM_SCREEN_Y = 120,
  parameter int AW           = 15,
  parameter int DW           = 8,
  parameter int RD_LAT       = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    posX,
  input  logic [8:0]    posY,
  input  logic [1:0]    scale,
  input  logic [9:0]    off_x,
  input  logic [8:0]    off_y,
  input  logic [DW-1:0] border_color,
  input  logic [DW-1:0] mem_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] pixel_out,
  output logic          in_window,
  output logic [7:0]    frame_cnt
);

  localparam logic [9:0] CAM_X_L = 10'(CAM_SCREEN_X);
  localparam logic [8:0] CAM_Y_L = 9'(CAM_SCREEN_Y);

  // Shadow configuration, frozen for the duration of a frame
  logic [1:0]    sh_scale;
  logic [9:0]    sh_off_x;
  logic [8:0]    sh_off_y;
  logic [DW-1:0] sh_border;

  // Configuration seen by the current position
  logic          frame_start;
  logic [1:0]    cur_scale;
  logic [9:0]    cur_off_x;
  logic [8:0]    cur_off_y;
  logic [DW-1:0] cur_border;
  logic [1:0]    shift;
  logic [9:0]    rx;
  logic [8:0]    ry;
  logic [9:0]    sx_c;
  logic [8:0]    sy_c;
  logic          win_c;

  // Stage 1 registers
  logic [9:0]    s1_sx;
  logic [8:0]    s1_sy;
  logic          s1_win;
  logic [DW-1:0] s1_border;

  // Stage 2 registers (mem_addr is the stage 2 address register)
  logic          s2_win;
  logic [DW-1:0] s2_border;
  logic [AW-1:0] addr_c;

  // Delay line matching the framebuffer read latency
  logic          win_dly    [RD_LAT];
  logic [DW-1:0] border_dly [RD_LAT];

  assign frame_start = (posX == '0) && (posY == '0);

  // Select the effective config and compute window membership for this position.
  // The frame-start pixel already uses the config being loaded, so the whole
  // frame, including its first pixel, sees one consistent configuration.
  always_comb begin
    cur_scale  = frame_start ? scale        : sh_scale;
    cur_off_x  = frame_start ? off_x        : sh_off_x;
    cur_off_y  = frame_start ? off_y        : sh_off_y;
    cur_border = frame_start ? border_color : sh_border;
    case (cur_scale)
      2'd0:    shift = 2'd0;
      2'd1:    shift = 2'd1;
      default: shift = 2'd2;
    endcase
    rx    = posX - cur_off_x;
    ry    = posY - cur_off_y;
    sx_c  = rx >> shift;
    sy_c  = ry >> shift;
    win_c = (posX >= cur_off_x) && (posY >= cur_off_y) &&
            (sx_c < CAM_X_L) && (sy_c < CAM_Y_L);
  end

  // Shadow config load and frame counter, both at frame start
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_scale  <= '0;
      sh_off_x  <= '0;
      sh_off_y  <= '0;
      sh_border <= '0;
      frame_cnt <= '0;
    end else if (frame_start) begin
      sh_scale  <= scale;
      sh_off_x  <= off_x;
      sh_off_y  <= off_y;
      sh_border <= border_color;
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Stage 1: register scaled camera coordinates and window flag
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sx     <= '0;
      s1_sy     <= '0;
      s1_win    <= 1'b0;
      s1_border <= '0;
    end else begin
      s1_sx     <= sx_c;
      s1_sy     <= sy_c;
      s1_win    <= win_c;
      s1_border <= cur_border;
    end
  end

  assign addr_c = AW'(s1_sy) * AW'(CAM_SCREEN_X) + AW'(s1_sx);

  // Stage 2: framebuffer address, forced to zero outside the window
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      s2_win    <= 1'b0;
      s2_border <= '0;
    end else begin
      mem_addr  <= s1_win ? addr_c : '0;
      s2_win    <= s1_win;
      s2_border <= s1_border;
    end
  end

  // Carry window flag and border colour alongside the memory read
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        win_dly[i]    <= 1'b0;
        border_dly[i] <= '0;
      end
    end else begin
      win_dly[0]    <= s2_win;
      border_dly[0] <= s2_border;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        win_dly[i]    <= win_dly[i-1];
        border_dly[i] <= border_dly[i-1];
      end
    end
  end

  // Output pixel mux: framebuffer data inside the window, border outside
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_out <= '0;
      in_window <= 1'b0;
    end else begin
      pixel_out <= win_dly[RD_LAT-1] ? mem_data : border_dly[RD_LAT-1];
      in_window <= win_dly[RD_LAT-1];
    end
  end

endmodule

// File: tb/tb_vga_frame_mapper.sv
// Scoreboard bench for vga_frame_mapper: expected address/pixel/window pushed
// when each position is driven, observed outputs logged every cycle, and each
// scenario task compares its own entries once the pipeline has drained.
module tb_vga_frame_mapper;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  posX;
  logic [8:0]  posY;
  logic [1:0]  scale;
  logic [9:0]  off_x;
  logic [8:0]  off_y;
  logic [7:0]  border_color;
  logic [7:0]  mem_data;
  logic [14:0] mem_addr;
  logic [7:0]  pixel_out;
  logic        in_window;
  logic [7:0]  frame_cnt;

  always #5 clk = ~clk;

  vga_frame_mapper #(
    .CAM_SCREEN_X(160),
    .CAM_SCREEN_Y(120),
    .AW(15),
    .DW(8),
    .RD_LAT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .posX(posX),
    .posY(posY),
    .scale(scale),
    .off_x(off_x),
    .off_y(off_y),
    .border_color(border_color),
    .mem_data(mem_data),
    .mem_addr(mem_addr),
    .pixel_out(pixel_out),
    .in_window(in_window),
    .frame_cnt(frame_cnt)
  );

  function automatic logic [7:0] memf(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5C;
  endfunction

  // Framebuffer with one cycle read latency
  always @(posedge clk) mem_data <= memf(mem_addr);

  typedef struct {
    int          e;
    logic [14:0] addr;
    logic [7:0]  pix;
    logic        win;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [14:0] obs_addr [4096];
  logic [7:0]  obs_pix  [4096];
  logic        obs_win  [4096];

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    obs_addr[cyc % 4096] = mem_addr;
    obs_pix[cyc % 4096]  = pixel_out;
    obs_win[cyc % 4096]  = in_window;
  end

  // Reference model state
  int m_scale = 0, m_ox = 0, m_oy = 0, m_border = 0, m_fc = 0;

  task automatic drive(input int x, input int y, input bit chk);
    exp_t r;
    int   s, sx, sy;
    bit   w;
    posX = 10'(x);
    posY = 9'(y);
    if (rst) begin
      m_scale = 0; m_ox = 0; m_oy = 0; m_border = 0; m_fc = 0;
      sb_q.delete();
    end else begin
      if (x == 0 && y == 0) begin
        m_scale = int'(scale); m_ox = int'(off_x); m_oy = int'(off_y);
        m_border = int'(border_color); m_fc = (m_fc + 1) % 256;
      end
      s  = (m_scale == 0) ? 0 : (m_scale == 1) ? 1 : 2;
      w  = (x >= m_ox) && (y >= m_oy);
      sx = 0; sy = 0;
      if (w) begin
        sx = (x - m_ox) >> s;
        sy = (y - m_oy) >> s;
        w  = (sx < 160) && (sy < 120);
      end
      r.e    = cyc + 1;
      r.addr = w ? 15'(sy * 160 + sx) : 15'd0;
      r.pix  = w ? memf(r.addr) : 8'(m_border);
      r.win  = w;
      if (chk) sb_q.push_back(r);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_cfg(input int s, input int ox, input int oy, input int b);
    scale = 2'(s); off_x = 10'(ox); off_y = 9'(oy); border_color = 8'(b);
  endtask

  task automatic test_reset();
    exp_t r;
    rst = 1'b1;
    set_cfg(0, 0, 0, 8'h11);
    drive(600, 400, 0);
    drive(600, 400, 0);
    @(negedge clk);
    n_cmp++; if (mem_addr !== 15'd0) begin n_bad++; $display("FAIL rst_addr: got %0d want 0", mem_addr); end
    n_cmp++; if (pixel_out !== 8'h00) begin n_bad++; $display("FAIL rst_pix: got %h want 00", pixel_out); end
    n_cmp++; if (in_window !== 1'b0) begin n_bad++; $display("FAIL rst_win: got %b want 0", in_window); end
    n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_fc: got %0d want 0", frame_cnt); end
    rst = 1'b0;
    drive(0, 0, 0);
    drive(5, 2, 0);
    drive(6, 2, 0);
    drive(7, 2, 0);
    n_cmp++; if (frame_cnt !== 8'd1) begin n_bad++; $display("FAIL pre_rst_fc: got %0d want 1", frame_cnt); end
    rst = 1'b1;
    drive(8, 2, 0);
    rst = 1'b0;
    n_cmp++; if (mem_addr !== 15'd0) begin n_bad++; $display("FAIL midrst_addr: got %0d want 0", mem_addr); end
    n_cmp++; if (pixel_out !== 8'h00) begin n_bad++; $display("FAIL midrst_pix: got %h want 00", pixel_out); end
    n_cmp++; if (in_window !== 1'b0) begin n_bad++; $display("FAIL midrst_win: got %b want 0", in_window); end
    n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL midrst_fc: got %0d want 0", frame_cnt); end
    drive(9, 2, 1);
    n_cmp++; if (pixel_out !== 8'h00) begin n_bad++; $display("FAIL flush_pix: got %h want 00", pixel_out); end
    n_cmp++; if (in_window !== 1'b0) begin n_bad++; $display("FAIL flush_win: got %b want 0", in_window); end
    drive(200, 2, 1);
    drive(10, 2, 1);
    for (int i = 0; i < 4; i++) drive(600, 400, 0);
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      n_cmp++; if (obs_addr[(r.e+1)%4096] !== r.addr) begin n_bad++; $display("FAIL postrst_addr e%0d: got %0d want %0d", r.e, obs_addr[(r.e+1)%4096], r.addr); end
      n_cmp++; if (obs_pix[(r.e+3)%4096] !== r.pix) begin n_bad++; $display("FAIL postrst_pix e%0d: got %h want %h", r.e, obs_pix[(r.e+3)%4096], r.pix); end
      n_cmp++; if (obs_win[(r.e+3)%4096] !== r.win) begin n_bad++; $display("FAIL postrst_win e%0d: got %b want %b", r.e, obs_win[(r.e+3)%4096], r.win); end
    end
  endtask

  task automatic test_1x();
    exp_t r;
    set_cfg(0, 0, 0, 8'h11);
    drive(0, 0, 0);
    drive(5, 2, 1);
    n_cmp++; if (mem_addr !== 15'd0 && 1'b0) begin n_bad++; end
    drive(1, 0, 1);
    drive(159, 0, 1);
    drive(0, 119, 1);
    drive(320, 7, 1);
    for (int i = 0; i < 4; i++) drive(600, 400, 0);
    n_cmp--;
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      n_cmp++; if (obs_addr[(r.e+1)%4096] !== r.addr) begin n_bad++; $display("FAIL 1x_addr e%0d: got %0d want %0d", r.e, obs_addr[(r.e+1)%4096], r.addr); end
      n_cmp++; if (obs_pix[(r.e+3)%4096] !== r.pix) begin n_bad++; $display("FAIL 1x_pix e%0d: got %h want %h", r.e, obs_pix[(r.e+3)%4096], r.pix); end
      n_cmp++; if (obs_win[(r.e+3)%4096] !== r.win) begin n_bad++; $display("FAIL 1x_win e%0d: got %b want %b", r.e, obs_win[(r.e+3)%4096], r.win); end
    end
  endtask

  task automatic test_2x_offset();
    exp_t r;
    set_cfg(1, 100, 50, 8'hA5);
    drive(0, 0, 0);
    drive(103, 55, 1);
    drive(99, 55, 1);
    drive(100, 49, 1);
    drive(419, 289, 1);
    drive(420, 289, 1);
    drive(419, 290, 1);
    for (int i = 0; i < 4; i++) drive(600, 400, 0);
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      n_cmp++; if (obs_addr[(r.e+1)%4096] !== r.addr) begin n_bad++; $display("FAIL 2x_addr e%0d: got %0d want %0d", r.e, obs_addr[(r.e+1)%4096], r.addr); end
      n_cmp++; if (obs_pix[(r.e+3)%4096] !== r.pix) begin n_bad++; $display("FAIL 2x_pix e%0d: got %h want %h", r.e, obs_pix[(r.e+3)%4096], r.pix); end
      n_cmp++; if (obs_win[(r.e+3)%4096] !== r.win) begin n_bad++; $display("FAIL 2x_win e%0d: got %b want %b", r.e, obs_win[(r.e+3)%4096], r.win); end
    end
  endtask

  task automatic test_border();
    exp_t r;
    set_cfg(0, 0, 0, 8'h03);
    drive(0, 0, 0);
    drive(160, 0, 1);
    drive(159, 119, 1);
    drive(0, 120, 1);
    drive(159, 120, 1);
    drive(639, 479, 1);
    for (int i = 0; i < 4; i++) drive(600, 400, 0);
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      n_cmp++; if (obs_addr[(r.e+1)%4096] !== r.addr) begin n_bad++; $display("FAIL border_addr e%0d: got %0d want %0d", r.e, obs_addr[(r.e+1)%4096], r.addr); end
      n_cmp++; if (obs_pix[(r.e+3)%4096] !== r.pix) begin n_bad++; $display("FAIL border_pix e%0d: got %h want %h", r.e, obs_pix[(r.e+3)%4096], r.pix); end
      n_cmp++; if (obs_win[(r.e+3)%4096] !== r.win) begin n_bad++; $display("FAIL border_win e%0d: got %b want %b", r.e, obs_win[(r.e+3)%4096], r.win); end
    end
  endtask

  task automatic test_4x();
    exp_t r;
    for (int s = 2; s <= 3; s++) begin
      set_cfg(s, 0, 0, 8'h7E);
      drive(0, 0, 0);
      drive(639, 479, 1);
      drive(4, 8, 1);
      drive(3, 3, 1);
    end
    for (int i = 0; i < 4; i++) drive(600, 400, 0);
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      n_cmp++; if (obs_addr[(r.e+1)%4096] !== r.addr) begin n_bad++; $display("FAIL 4x_addr e%0d: got %0d want %0d", r.e, obs_addr[(r.e+1)%4096], r.addr); end
      n_cmp++; if (obs_pix[(r.e+3)%4096] !== r.pix) begin n_bad++; $display("FAIL 4x_pix e%0d: got %h want %h", r.e, obs_pix[(r.e+3)%4096], r.pix); end
      n_cmp++; if (obs_win[(r.e+3)%4096] !== r.win) begin n_bad++; $display("FAIL 4x_win e%0d: got %b want %b", r.e, obs_win[(r.e+3)%4096], r.win); end
    end
  endtask

  task automatic test_shadow_frame();
    exp_t r;
    set_cfg(0, 0, 0, 8'h22);
    while (m_fc != 255) drive(0, 0, 0);
    n_cmp++; if (frame_cnt !== 8'd255) begin n_bad++; $display("FAIL fc_255: got %0d want 255", frame_cnt); end
    drive(10, 100, 1);
    set_cfg(1, 0, 0, 8'h22);
    drive(10, 200, 1);
    drive(10, 100, 1);
    drive(0, 0, 0);
    n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL fc_wrap: got %0d want 0", frame_cnt); end
    drive(10, 100, 1);
    for (int i = 0; i < 4; i++) drive(600, 400, 0);
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      n_cmp++; if (obs_addr[(r.e+1)%4096] !== r.addr) begin n_bad++; $display("FAIL shadow_addr e%0d: got %0d want %0d", r.e, obs_addr[(r.e+1)%4096], r.addr); end
      n_cmp++; if (obs_pix[(r.e+3)%4096] !== r.pix) begin n_bad++; $display("FAIL shadow_pix e%0d: got %h want %h", r.e, obs_pix[(r.e+3)%4096], r.pix); end
      n_cmp++; if (obs_win[(r.e+3)%4096] !== r.win) begin n_bad++; $display("FAIL shadow_win e%0d: got %b want %b", r.e, obs_win[(r.e+3)%4096], r.win); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t r;
    int   x, y;
    for (int i = 0; i < 60; i++) begin
      if (i == 0 || i == 30) begin
        set_cfg($urandom_range(0, 3), $urandom_range(0, 300), $urandom_range(0, 200), $urandom_range(0, 255));
        drive(0, 0, 0);
      end else begin
        set_cfg($urandom_range(0, 3), $urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 255));
        x = $urandom_range(0, 639);
        y = $urandom_range(0, 479);
        if (x == 0 && y == 0) x = 1;
        drive(x, y, 1);
      end
    end
    for (int i = 0; i < 4; i++) drive(600, 400, 0);
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      n_cmp++; if (obs_addr[(r.e+1)%4096] !== r.addr) begin n_bad++; $display("FAIL b2b_addr e%0d: got %0d want %0d", r.e, obs_addr[(r.e+1)%4096], r.addr); end
      n_cmp++; if (obs_pix[(r.e+3)%4096] !== r.pix) begin n_bad++; $display("FAIL b2b_pix e%0d: got %h want %h", r.e, obs_pix[(r.e+3)%4096], r.pix); end
      n_cmp++; if (obs_win[(r.e+3)%4096] !== r.win) begin n_bad++; $display("FAIL b2b_win e%0d: got %b want %b", r.e, obs_win[(r.e+3)%4096], r.win); end
    end
  endtask

  initial begin
    rst = 1'b1;
    posX = 10'd600;
    posY = 9'd400;
    set_cfg(0, 0, 0, 0);
    test_reset();
    test_1x();
    test_2x_offset();
    test_border();
    test_4x();
    test_shadow_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
